lc3b_mem_responder: RTL and testbench

Memory-side responder for the LC-3b core's MAR/MDR memory interface. It accepts word reads and byte-enabled writes from the datapath/control pair and completes each after a fixed, parameterised latency with a one-cycle mem_resp pulse. Inside, it is a word-organised storage array behind a small request FSM. It serves as the behavioural main memory for core-level simulation and as the template for a later cache-to-memory responder.

---
 rtl/lc3b_mem_responder_pkg.sv | 16 +
 rtl/lc3b_mem_responder_array.sv | 33 +++
 rtl/lc3b_mem_responder.sv | 143 ++++++++++++++
 tb/tb_lc3b_mem_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b types for the memory responder: word, byte-enable and the
// responder FSM state so benches can probe it.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_be;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lc3b_memresp_state_t;

    localparam int unsigned LC3B_MEMRESP_CNT_W = 4;

endpackage

// File: rtl/lc3b_mem_responder_array.sv
// Word-organised storage for the memory responder: byte-lane synchronous
// write, registered read whose output holds until the next read.
module lc3b_mem_array
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic                 re,
    input  lc3b_mem_be           be,
    input  logic [ADDR_BITS-1:0] addr,
    input  lc3b_word             wdata,
    output lc3b_word             rdata
);

    lc3b_word mem [2**ADDR_BITS];

    // Storage itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency MAR/MDR memory responder for the LC-3b core.
// Optional macro MEM_PROTOCOL_CHECK_EN adds the sticky mem_err protocol flag.
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_read,
    input  logic       mem_write,
    input  lc3b_mem_be mem_byte_enable,
    input  lc3b_word   mem_address,
    input  lc3b_word   mem_wdata,
    output lc3b_word   mem_rdata,
    output logic       mem_resp
`ifdef MEM_PROTOCOL_CHECK_EN
    ,
    output logic       mem_err
`endif
);

    lc3b_memresp_state_t             state_q, state_d;
    logic [LC3B_MEMRESP_CNT_W-1:0]   cnt_q, cnt_d;
    logic                            accept, commit;
    logic                            req;

    logic                 cap_write_q;
    logic [ADDR_BITS-1:0] cap_idx_q;
    lc3b_word             cap_wdata_q;
    lc3b_mem_be           cap_be_q;

    logic                 acc_write;
    logic [ADDR_BITS-1:0] acc_idx;
    lc3b_word             acc_wdata;
    lc3b_mem_be           acc_be;

    assign req = mem_read | mem_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LC3B_MEMRESP_CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == 1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write_q <= mem_write;
            cap_idx_q   <= mem_address[ADDR_BITS:1];
            cap_wdata_q <= mem_wdata;
            cap_be_q    <= mem_byte_enable;
        end
    end

    // With LATENCY==1 the commit edge is also the accept edge, so the live
    // request fields feed the array instead of the (not yet loaded) captures.
    assign acc_write = accept ? mem_write                  : cap_write_q;
    assign acc_idx   = accept ? mem_address[ADDR_BITS:1]   : cap_idx_q;
    assign acc_wdata = accept ? mem_wdata                  : cap_wdata_q;
    assign acc_be    = accept ? mem_byte_enable            : cap_be_q;

    lc3b_mem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit & acc_write & rst_n),
        .re    (commit & ~acc_write & rst_n),
        .be    (acc_be),
        .addr  (acc_idx),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    assign mem_resp = (state_q == RESP);

`ifdef MEM_PROTOCOL_CHECK_EN
    lc3b_word cap_addr_q;
    logic     proto_evt;

    always_ff @(posedge clk) begin
        if (accept) cap_addr_q <= mem_address;
    end

    assign proto_evt = (((state_q == IDLE) || (state_q == BUSY)) && mem_read && mem_write)
                     || ((state_q == BUSY) && !req)
                     || ((state_q == BUSY) && (mem_address != cap_addr_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         mem_err <= 1'b0;
        else if (proto_evt) mem_err <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && proto_evt)
            $error("lc3b_mem_responder: protocol violation in state %s", state_q.name());
    end
`endif
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Randomised self-checking bench for lc3b_mem_responder with LATENCY=3 and
// LATENCY=1 instances checked against a word-array reference model.
module tb_lc3b_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        mem_read  [2];
    logic        mem_write [2];
    logic [1:0]  be        [2];
    logic [15:0] addr      [2];
    logic [15:0] wdata     [2];
    logic [15:0] rdata     [2];
    logic        resp      [2];
`ifdef MEM_PROTOCOL_CHECK_EN
    logic        err       [2];
`endif

    int checks = 0;
    int errors = 0;
    int lat_of [2] = '{3, 1};

    logic [15:0] model  [2][256];
    logic [15:0] ref_rd [2];

    always #5 clk = ~clk;

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .mem_byte_enable(be[0]), .mem_address(addr[0]), .mem_wdata(wdata[0]),
        .mem_rdata(rdata[0]), .mem_resp(resp[0])
`ifdef MEM_PROTOCOL_CHECK_EN
        , .mem_err(err[0])
`endif
    );

    lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .mem_byte_enable(be[1]), .mem_address(addr[1]), .mem_wdata(wdata[1]),
        .mem_rdata(rdata[1]), .mem_resp(resp[1])
`ifdef MEM_PROTOCOL_CHECK_EN
        , .mem_err(err[1])
`endif
    );

    // Reference model: byte-lane write into a word array, reads update the
    // held read value; returns the value mem_rdata should show at mem_resp.
    function automatic logic [15:0] model_txn(input int d, input bit w,
                                              input logic [15:0] a, input logic [15:0] wd,
                                              input logic [1:0] b);
        int idx;
        idx = int'(a[8:1]);
        if (w) begin
            if (b[0]) model[d][idx][7:0]  = wd[7:0];
            if (b[1]) model[d][idx][15:8] = wd[15:8];
        end else begin
            ref_rd[d] = model[d][idx];
        end
        return ref_rd[d];
    endfunction

    // Issues one request from an IDLE cycle and holds it until mem_resp.
    task automatic run_txn(input int d, input bit w, input bit r,
                           input logic [15:0] a, input logic [15:0] wd, input logic [1:0] b,
                           output int lat, output logic [15:0] rd);
        @(posedge clk); #1;
        mem_read[d] = r; mem_write[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        lat = -1;
        rd  = '0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (resp[d] === 1'b1) begin
                lat = k;
                rd  = rdata[d];
            end
        end
        mem_read[d] = 1'b0; mem_write[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
            be[d] = 2'b00; addr[d] = '0; wdata[d] = '0; ref_rd[d] = '0;
            for (int i = 0; i < 256; i++) model[d][i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (resp[d] !== 1'b0) begin
                errors++; $display("FAIL reset_resp[%0d]: got %b expected 0", d, resp[d]);
            end
            checks++;
            if (rdata[d] !== 16'h0000) begin
                errors++; $display("FAIL reset_rdata[%0d]: got %h expected 0000", d, rdata[d]);
            end
`ifdef MEM_PROTOCOL_CHECK_EN
            checks++;
            if (err[d] !== 1'b0) begin
                errors++; $display("FAIL reset_err[%0d]: got %b expected 0", d, err[d]);
            end
`endif
        end
        @(posedge clk); #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    endtask

    task automatic test_preload();
        int lat; logic [15:0] rd, exp, wd;
        for (int i = 0; i < 32; i++) begin
            wd  = 16'($urandom);
            exp = model_txn(0, 1'b1, 16'(i << 1), wd, 2'b11);
            run_txn(0, 1'b1, 1'b0, 16'(i << 1), wd, 2'b11, lat, rd);
            checks++;
            if (lat !== 3 || rd !== exp) begin
                errors++; $display("FAIL preload[%0d]: got lat %0d rdata %h expected lat 3 rdata %h", i, lat, rd, exp);
            end
        end
    endtask

    task automatic test_read();
        int lat; logic [15:0] rd, exp;
        exp = model_txn(0, 1'b1, 16'h0020, 16'hBEEF, 2'b11);
        run_txn(0, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 2'b11, lat, rd);
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL read_setup_lat: got %0d expected 3", lat);
        end
        exp = model_txn(0, 1'b0, 16'h0020, 16'h0, 2'b00);
        run_txn(0, 1'b0, 1'b1, 16'h0020, 16'h0, 2'b00, lat, rd);
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL read_lat: got %0d expected 3", lat);
        end
        checks++;
        if (rd !== 16'hBEEF || rd !== exp) begin
            errors++; $display("FAIL read_data: got %h expected %h", rd, 16'hBEEF);
        end
    endtask

    task automatic test_byte_write();
        int lat; logic [15:0] rd, exp;
        logic [1:0]  bes  [3] = '{2'b01, 2'b10, 2'b00};
        logic [15:0] want [3] = '{16'hBE34, 16'h1234, 16'h1234};
        for (int i = 0; i < 3; i++) begin
            exp = model_txn(0, 1'b1, 16'h0020, 16'h1234, bes[i]);
            run_txn(0, 1'b1, 1'b0, 16'h0020, 16'h1234, bes[i], lat, rd);
            checks++;
            if (lat !== 3 || rd !== exp) begin
                errors++; $display("FAIL bytewr_resp[%0d]: got lat %0d rdata %h expected lat 3 rdata %h", i, lat, rd, exp);
            end
            exp = model_txn(0, 1'b0, 16'h0020, 16'h0, 2'b00);
            run_txn(0, 1'b0, 1'b1, 16'h0020, 16'h0, 2'b00, lat, rd);
            checks++;
            if (lat !== 3 || rd !== want[i] || rd !== exp) begin
                errors++; $display("FAIL bytewr_read[%0d]: got lat %0d rdata %h expected lat 3 rdata %h", i, lat, rd, want[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [15:0] rd, exp, a, wd; logic [1:0] b; bit w;
        for (int i = 0; i < 40; i++) begin
            w  = 1'($urandom_range(0, 1));
            a  = (16'($urandom) & 16'hFE00) | 16'($urandom_range(0, 31) << 1) | 16'($urandom_range(0, 1));
            wd = 16'($urandom);
            b  = 2'($urandom_range(0, 3));
            exp = model_txn(0, w, a, wd, b);
            run_txn(0, w, !w, a, wd, b, lat, rd);
            checks++;
            if (lat !== 3 || rd !== exp) begin
                errors++; $display("FAIL random[%0d] w=%0b a=%h: got lat %0d rdata %h expected lat 3 rdata %h", i, w, a, lat, rd, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] rd, exp, wd;
        bit prev;
        wd  = 16'($urandom);
        exp = model_txn(1, 1'b1, 16'h0020, wd, 2'b11);
        run_txn(1, 1'b1, 1'b0, 16'h0020, wd, 2'b11, lat, rd);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL b2b_write_lat: got %0d expected 1", lat);
        end
        exp  = model[1][16];
        prev = 1'b0;
        @(posedge clk); #1;
        mem_read[1] = 1'b1; addr[1] = 16'h0020;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 6) addr[1] = 16'h0021;
            checks++;
            if (resp[1] !== 1'(k % 2) || (prev && resp[1] === 1'b1)) begin
                errors++; $display("FAIL b2b_resp cycle %0d: got %b expected %0d", k, resp[1], k % 2);
            end
            if (k % 2 == 1) begin
                checks++;
                if (rdata[1] !== exp) begin
                    errors++; $display("FAIL b2b_rdata cycle %0d: got %h expected %h", k, rdata[1], exp);
                end
            end
            prev = resp[1];
        end
        mem_read[1] = 1'b0;
        ref_rd[1] = exp;
    endtask

    task automatic test_abort();
        int lat; logic [15:0] rd, exp;
        bit seen;
        @(posedge clk); #1;
        mem_write[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 16'hAAAA; be[0] = 2'b11;
        @(posedge clk); #1;
        mem_write[0] = 1'b0;
        seen = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            if (resp[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_resp: got resp 1 expected 0");
        end
        checks++;
        if (rdata[0] !== ref_rd[0]) begin
            errors++; $display("FAIL abort_rdata: got %h expected %h", rdata[0], ref_rd[0]);
        end
        exp = model_txn(0, 1'b0, 16'h0020, 16'h0, 2'b00);
        run_txn(0, 1'b0, 1'b1, 16'h0020, 16'h0, 2'b00, lat, rd);
        checks++;
        if (lat !== 3 || rd !== exp) begin
            errors++; $display("FAIL abort_read: got lat %0d rdata %h expected lat 3 rdata %h", lat, rd, exp);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd, exp;
        bit seen;
        @(posedge clk); #1;
        mem_write[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 16'h5555; be[0] = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[0] = 1'b0; mem_write[0] = 1'b0;
        seen = 1'b0;
        #1;
        if (resp[0] !== 1'b0) seen = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (resp[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rstmid_resp: got resp 1 expected 0");
        end
        checks++;
        if (rdata[0] !== 16'h0000) begin
            errors++; $display("FAIL rstmid_rdata: got %h expected 0000", rdata[0]);
        end
        ref_rd[0] = '0;
        rst_n[0] = 1'b1;
        exp = model_txn(0, 1'b0, 16'h0020, 16'h0, 2'b00);
        run_txn(0, 1'b0, 1'b1, 16'h0020, 16'h0, 2'b00, lat, rd);
        checks++;
        if (lat !== 3 || rd !== exp) begin
            errors++; $display("FAIL rstmid_read: got lat %0d rdata %h expected lat 3 rdata %h", lat, rd, exp);
        end
    endtask

`ifdef MEM_PROTOCOL_CHECK_EN
    task automatic test_protocol_err();
        int lat; logic [15:0] rd, exp;
        checks++;
        if (err[0] !== 1'b0) begin
            errors++; $display("FAIL err_before: got %b expected 0", err[0]);
        end
        @(posedge clk); #1;
        mem_read[0] = 1'b1; mem_write[0] = 1'b1; addr[0] = 16'h0022; wdata[0] = 16'h0F0F; be[0] = 2'b11;
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                checks++;
                if (err[0] !== 1'b1) begin
                    errors++; $display("FAIL err_set: got %b expected 1", err[0]);
                end
            end
            if (resp[0] === 1'b1) lat = k;
        end
        mem_read[0] = 1'b0; mem_write[0] = 1'b0;
        exp = model_txn(0, 1'b1, 16'h0022, 16'h0F0F, 2'b11);
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL err_txn_lat: got %0d expected 3", lat);
        end
        exp = model_txn(0, 1'b0, 16'h0022, 16'h0, 2'b00);
        run_txn(0, 1'b0, 1'b1, 16'h0022, 16'h0, 2'b00, lat, rd);
        checks++;
        if (rd !== 16'h0F0F || rd !== exp) begin
            errors++; $display("FAIL err_as_write: got %h expected 0f0f", rd);
        end
        checks++;
        if (err[0] !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got %b expected 1", err[0]);
        end
        rst_n[0] = 1'b0;
        #2;
        checks++;
        if (err[0] !== 1'b0) begin
            errors++; $display("FAIL err_clear: got %b expected 0", err[0]);
        end
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        ref_rd[0] = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_preload();
        test_read();
        test_byte_write();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef MEM_PROTOCOL_CHECK_EN
        test_protocol_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion expected finish before 500000");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
